adc_frame_serializer: RTL and testbench
=======================================

ADC_FRAME_SERIALIZER -- requirements
Module: adc_frame_serializer

Interface
REQ-001 SHALL have parameter W_CHAN, default 5, channel index width.
REQ-002 SHALL have parameter N_CHAN, default 8, number of channels (N_CHAN <= 2**W_CHAN).
REQ-003 SHALL have parameter W_DATA, default 18, signed sample width.
REQ-004 SHALL have parameters W_WR_ADDR 16, W_WR_CHAN 16, W_WR_DATA 48, config-bus widths.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk_in  input  1  clock; rst_in  input  1  reset (asynchronous, active-low).
REQ-006 SHALL have frame_valid_in  input  1  strobe, one full parallel frame present.
REQ-007 SHALL have frame_data_in  input  N_CHAN*W_DATA  packed signed samples, channel i at bits [i*W_DATA +: W_DATA].
REQ-008 SHALL have wr_en / wr_addr / wr_chan / wr_data  input  1 / W_WR_ADDR / W_WR_CHAN / W_WR_DATA  config write bus.
REQ-009 SHALL have dv_out  output  1; chan_out  output  W_CHAN; data_out  output  W_DATA signed: serial sample stream.
REQ-010 SHALL have busy_out  output  1  serialization in progress; overrun_out  output  1  sticky dropped-frame flag.

Function
REQ-011 SHALL keep a per-channel enable mask; write with wr_addr==ser_en_addr and wr_chan<N_CHAN sets mask[wr_chan]<=wr_data[0]; wr_chan>=N_CHAN ignored.
REQ-012 SHALL use a two-state FSM IDLE/SCAN; in IDLE a sampled frame_valid_in captures frame_data_in and snapshots the mask.
REQ-013 SHALL, after capture at edge k, register the lowest enabled channel at edge k+1 and one further enabled channel per edge in ascending index, with no bubbles for disabled channels.
REQ-014 SHALL drive dv_out high exactly once per enabled channel per frame; chan_out/data_out hold the last values when dv_out is low.
REQ-015 SHALL hold busy_out high from the capture edge until the edge registering the last enabled channel, then return to IDLE.
REQ-016 SHALL accept a frame_valid_in sampled at the edge registering the last enabled channel (zero-bubble back-to-back); its first channel follows at the next edge.
REQ-017 SHALL drop any other frame_valid_in sampled while in SCAN and set overrun_out; the current frame completes unaffected.
REQ-018 SHALL, with a snapshotted mask of all zeros, accept the frame, emit nothing, keep busy_out low and never set overrun.
REQ-019 SHALL apply mask writes only at the next frame capture.
REQ-020 SHALL clear overrun_out one edge after a write with wr_addr==ser_clr_rqst; a simultaneous overrun event wins (flag stays set).

Reset
REQ-021 SHALL, on rst_in low, immediately force IDLE, dv_out=0, chan_out=0, data_out=0, busy_out=0, overrun_out=0, frame counter=0, mask=SER_EN_INIT (all ones).
REQ-022 SHALL abandon a frame in progress on reset with no further dv_out after release.

Configuration
REQ-023 SHALL, with SER_TEST_PATTERN_EN defined, add register ser_tp_addr (wr_data[0]) selecting test mode; when set, data_out = ({frame_cnt, chan} truncated to W_DATA), frame_cnt incrementing (wrapping) per accepted frame.
REQ-024 SHALL, without SER_TEST_PATTERN_EN, ignore ser_tp_addr, omit the counter, and always pass captured samples.

Structure
REQ-025 SHALL take ser_en_addr, ser_clr_rqst, ser_tp_addr from the shared endpoint-map package and SER_EN_INIT from the shared init package.
REQ-026 SHALL isolate next-enabled-channel search in sub-module ser_next_chan (mask + current index -> next index, last flag).

Verification
REQ-027 SHALL cover: mask 0xFF, frame ch i = i*10 -> 8 consecutive dv_out, chan 0..7, data 0,10..70, busy 8 cycles.
REQ-028 SHALL cover: mask 0xA5 -> dv_out on chan 0,2,5,7 in 4 consecutive cycles.
REQ-029 SHALL cover: second frame_valid_in 3 cycles after first (mask 0xFF) -> dropped, overrun_out=1, first frame intact; clr write -> overrun_out=0.
REQ-030 SHALL cover: frames every 8 cycles with mask 0xFF -> continuous dv_out, no overrun.
REQ-031 SHALL cover: rst_in low at 4th emitted channel -> all outputs 0 at once, no dv_out after release until next frame.
REQ-032 SHALL cover (macro on): test mode, 3 frames -> data_out on ch 2 of frame 3 equals (2<<W_CHAN)|2.

Source files
------------

// File: rtl/adc_frame_serializer_pkg.sv
// adc_frame_serializer_pkg: endpoint map, init values and FSM encodings shared by the serializer.
package adc_frame_serializer_pkg;
  localparam logic [15:0] ser_en_addr  = 16'h0010;
  localparam logic [15:0] ser_clr_rqst = 16'h0011;
  localparam logic [15:0] ser_tp_addr  = 16'h0012;
  localparam logic [31:0] SER_EN_INIT  = '1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
endpackage

// File: rtl/adc_frame_serializer_ser_next_chan.sv
// ser_next_chan: lowest enabled channel at or above a start index, and whether it is the final one.
module ser_next_chan #(
  parameter int W_CHAN = 5,
  parameter int N_CHAN = 8
) (
  input  logic [N_CHAN-1:0] mask,
  input  logic [W_CHAN-1:0] from,
  output logic [W_CHAN-1:0] nxt,
  output logic              any,
  output logic              last
);
  logic more;
  // descending scan so the last hit is the lowest index; a second hit means more remain
  always_comb begin
    nxt = '0;
    any = 1'b0;
    more = 1'b0;
    for (int i = N_CHAN - 1; i >= 0; i--)
      if (mask[i] && i >= int'(from)) begin
        more = more | any;
        any = 1'b1;
        nxt = W_CHAN'(i);
      end
    last = any && !more;
  end
endmodule

// File: rtl/adc_frame_serializer.sv
// adc_frame_serializer: parallel ADC frame to per-channel serial stream with enable mask and overrun flag.
// Optional SER_TEST_PATTERN_EN replaces samples with {frame_cnt, chan} when test mode is set.
module adc_frame_serializer
  import adc_frame_serializer_pkg::*;
#(
  parameter int W_CHAN    = 5,
  parameter int N_CHAN    = 8,
  parameter int W_DATA    = 18,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_CHAN = 16,
  parameter int W_WR_DATA = 48
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     frame_valid_in,
  input  logic [N_CHAN*W_DATA-1:0] frame_data_in,
  input  logic                     wr_en,
  input  logic [W_WR_ADDR-1:0]     wr_addr,
  input  logic [W_WR_CHAN-1:0]     wr_chan,
  input  logic [W_WR_DATA-1:0]     wr_data,
  output logic                     dv_out,
  output logic [W_CHAN-1:0]        chan_out,
  output logic signed [W_DATA-1:0] data_out,
  output logic                     busy_out,
  output logic                     overrun_out
);
  logic [0:0] state;
  logic [N_CHAN-1:0] mask, cap_mask;
  logic [N_CHAN*W_DATA-1:0] cap_data;
  logic [W_CHAN-1:0] ptr, nxt;
  logic any, last, en_wr, clr_wr, emit, accept, drop;
  logic [W_DATA-1:0] samp, out_data;
  logic unused_bits;
  ser_next_chan #(.W_CHAN(W_CHAN), .N_CHAN(N_CHAN)) u_next (
    .mask(cap_mask), .from(ptr), .nxt(nxt), .any(any), .last(last)
  );
  assign en_wr = wr_en && wr_addr == W_WR_ADDR'(ser_en_addr);
  assign clr_wr = wr_en && wr_addr == W_WR_ADDR'(ser_clr_rqst);
  assign emit = state == SCAN && any;
  assign accept = frame_valid_in && (state == IDLE || (emit && last));
  assign drop = frame_valid_in && !accept;
  assign samp = cap_data[nxt*W_DATA +: W_DATA];
  assign unused_bits = ^wr_data[W_WR_DATA-1:1];
`ifdef SER_TEST_PATTERN_EN
  logic tp_en;
  logic [W_DATA-W_CHAN-1:0] frame_cnt, cap_cnt;
  assign out_data = tp_en ? {cap_cnt, nxt} : samp;
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      tp_en <= 1'b0;
      frame_cnt <= '0;
      cap_cnt <= '0;
    end else begin
      if (wr_en && wr_addr == W_WR_ADDR'(ser_tp_addr)) tp_en <= wr_data[0];
      if (accept) begin
        cap_cnt <= frame_cnt;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
`else
  assign out_data = samp;
`endif
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      state <= IDLE;
      mask <= SER_EN_INIT[N_CHAN-1:0];
      cap_mask <= '0;
      cap_data <= '0;
      ptr <= '0;
      dv_out <= 1'b0;
      chan_out <= '0;
      data_out <= '0;
      busy_out <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      for (int i = 0; i < N_CHAN; i++)
        if (en_wr && wr_chan == W_WR_CHAN'(i)) mask[i] <= wr_data[0];
      overrun_out <= drop || (overrun_out && !clr_wr);
      dv_out <= emit;
      if (emit) begin
        chan_out <= nxt;
        data_out <= out_data;
        ptr <= nxt + 1'b1;
      end
      if (accept) begin
        cap_data <= frame_data_in;
        cap_mask <= mask;
        ptr <= '0;
        state <= |mask ? SCAN : IDLE;
        busy_out <= |mask;
      end else if (state == SCAN && (last || !any)) begin
        state <= IDLE;
        busy_out <= 1'b0;
      end
    end
endmodule

// File: tb/tb_adc_frame_serializer.sv
// tb_adc_frame_serializer: table-driven mask vectors plus hand sequences for overrun, back-to-back and reset.
module tb_adc_frame_serializer;
  import adc_frame_serializer_pkg::*;
  localparam int W_CHAN = 5, N_CHAN = 8, W_DATA = 18;
  logic clk_in = 1'b0, rst_in, frame_valid_in, wr_en;
  logic [N_CHAN*W_DATA-1:0] frame_data_in;
  logic [15:0] wr_addr, wr_chan;
  logic [47:0] wr_data;
  logic dv_out, busy_out, overrun_out;
  logic [W_CHAN-1:0] chan_out;
  logic signed [W_DATA-1:0] data_out;
  int checks = 0, errors = 0;
  typedef struct {
    logic [7:0]  mask;
    int          n;
    logic [31:0] chans;
  } vec_t;
  vec_t vecs[6];

  adc_frame_serializer dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_valid_in(frame_valid_in), .frame_data_in(frame_data_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_chan(wr_chan), .wr_data(wr_data),
    .dv_out(dv_out), .chan_out(chan_out), .data_out(data_out), .busy_out(busy_out), .overrun_out(overrun_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] c, input logic d);
    wr_en = 1'b1; wr_addr = a; wr_chan = c; wr_data = {47'b0, d};
    tick;
    wr_en = 1'b0;
  endtask

  task automatic set_mask(input logic [7:0] m);
    for (int i = 0; i < 8; i++) wr(ser_en_addr, 16'(i), m[i]);
  endtask

  task automatic load(input int base);
    for (int i = 0; i < N_CHAN; i++) frame_data_in[i*W_DATA +: W_DATA] = W_DATA'(base + i * 10);
  endtask

  initial begin
    vecs[0] = '{8'hFF, 8, 32'h76543210};
    vecs[1] = '{8'hA5, 4, 32'h00007520};
    vecs[2] = '{8'h3C, 4, 32'h00005432};
    vecs[3] = '{8'h80, 1, 32'h00000007};
    vecs[4] = '{8'h01, 1, 32'h00000000};
    vecs[5] = '{8'h00, 0, 32'h00000000};
    rst_in = 1'b0; frame_valid_in = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_chan = '0; wr_data = '0; frame_data_in = '0;
    #12;
    check("rst_dv", 32'(dv_out), 0);
    check("rst_chan", 32'(chan_out), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_ovr", 32'(overrun_out), 0);
    tick;
    rst_in = 1'b1;
    tick;

    // mask table: capture, then n consecutive emissions in ascending order
    for (int v = 0; v < 6; v++) begin
      set_mask(vecs[v].mask);
      load(0);
      frame_valid_in = 1'b1;
      tick;
      frame_valid_in = 1'b0;
      check("cap_busy", 32'(busy_out), 32'(vecs[v].mask != 0));
      check("cap_dv", 32'(dv_out), 0);
      for (int j = 0; j < vecs[v].n; j++) begin
        logic [3:0] c;
        c = vecs[v].chans[j*4 +: 4];
        tick;
        check("tbl_dv", 32'(dv_out), 1);
        check("tbl_chan", 32'(chan_out), 32'(c));
        check("tbl_data", 32'(data_out), 32'(c) * 10);
        check("tbl_busy", 32'(busy_out), 32'(j < vecs[v].n - 1));
      end
      tick;
      check("tbl_end_dv", 32'(dv_out), 0);
      check("tbl_end_busy", 32'(busy_out), 0);
      check("tbl_end_ovr", 32'(overrun_out), 0);
      if (vecs[v].n > 0)
        check("tbl_hold_chan", 32'(chan_out), 32'(vecs[v].chans[(vecs[v].n-1)*4 +: 4]));
    end

    // overrun: second strobe 3 cycles in is dropped; mid-frame mask write waits for next capture
    set_mask(8'hFF);
    load(0);
    frame_valid_in = 1'b1;
    tick;
    frame_valid_in = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (j == 2) begin frame_valid_in = 1'b1; load(5); end
      if (j == 4) begin wr_en = 1'b1; wr_addr = ser_en_addr; wr_chan = 16'd5; wr_data = '0; end
      if (j == 5) begin frame_valid_in = 1'b1; wr_en = 1'b1; wr_addr = ser_clr_rqst; end
      tick;
      frame_valid_in = 1'b0; wr_en = 1'b0;
      check("ovr_dv", 32'(dv_out), 1);
      check("ovr_chan", 32'(chan_out), 32'(j));
      check("ovr_data", 32'(data_out), 32'(j * 10));
      if (j == 2) check("ovr_set", 32'(overrun_out), 1);
      if (j == 5) check("ovr_wins_clr", 32'(overrun_out), 1);
    end
    tick;
    check("ovr_end_dv", 32'(dv_out), 0);
    check("ovr_sticky", 32'(overrun_out), 1);
    wr(ser_clr_rqst, 16'd0, 1'b0);
    check("ovr_clr", 32'(overrun_out), 0);
    load(0);
    frame_valid_in = 1'b1;
    tick;
    frame_valid_in = 1'b0;
    for (int j = 0; j < 7; j++) begin
      tick;
      check("newmask_chan", 32'(chan_out), 32'(j < 5 ? j : j + 1));
    end
    tick;
    check("newmask_end_dv", 32'(dv_out), 0);

    // back-to-back frames every 8 cycles
    set_mask(8'hFF);
    load(0);
    frame_valid_in = 1'b1;
    tick;
    frame_valid_in = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 8; j++) begin
        if (j == 7 && f < 2) begin frame_valid_in = 1'b1; load((f + 1) * 100); end
        tick;
        frame_valid_in = 1'b0;
        check("b2b_dv", 32'(dv_out), 1);
        check("b2b_chan", 32'(chan_out), 32'(j));
        check("b2b_data", 32'(data_out), 32'(f * 100 + j * 10));
        check("b2b_busy", 32'(busy_out), 32'(j < 7 || f < 2));
        check("b2b_ovr", 32'(overrun_out), 0);
      end
    tick;
    check("b2b_end_dv", 32'(dv_out), 0);

    // reset at the 4th emitted channel
    load(0);
    frame_valid_in = 1'b1;
    tick;
    frame_valid_in = 1'b0;
    repeat (4) tick;
    check("pre_rst_chan", 32'(chan_out), 3);
    #2 rst_in = 1'b0;
    #1;
    check("arst_dv", 32'(dv_out), 0);
    check("arst_chan", 32'(chan_out), 0);
    check("arst_data", 32'(data_out), 0);
    check("arst_busy", 32'(busy_out), 0);
    check("arst_ovr", 32'(overrun_out), 0);
    tick;
    tick;
    rst_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      check("post_rst_dv", 32'(dv_out), 0);
      check("post_rst_busy", 32'(busy_out), 0);
    end

`ifdef SER_TEST_PATTERN_EN
    wr(ser_tp_addr, 16'd0, 1'b1);
    for (int f = 0; f < 3; f++) begin
      load(0);
      frame_valid_in = 1'b1;
      tick;
      frame_valid_in = 1'b0;
      for (int j = 0; j < 8; j++) begin
        tick;
        if (f == 1 && j == 3) check("tp_f2_ch3", 32'(data_out), (1 << W_CHAN) | 3);
        if (f == 2 && j == 2) check("tp_f3_ch2", 32'(data_out), (2 << W_CHAN) | 2);
      end
      tick;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
